// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB register-bank back-end:
//   - apb_state_e : protocol FSM encoding (IDLE / SETUP / ACCESS)
//   - RESP_OK/ERR : PSLVERR encodings
//   - CNT_W       : width of the wait-state counter (covers 0..15)
//   - get_slice() : extracts element idx of width dw from a packed bus
// -----------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MAX_DW    = 32;
  localparam int unsigned MAX_BUS_W = 256;

  // Callers zero-extend their bus to MAX_BUS_W and truncate the result to
  // their own data width; dw must not exceed MAX_DW.
  function automatic logic [MAX_DW-1:0] get_slice(input logic [MAX_BUS_W-1:0] bus,
                                                  input int unsigned        idx,
                                                  input int unsigned        dw);
    logic [MAX_DW-1:0] mask;
    // For dw == MAX_DW the shift wraps to 0 and the subtraction yields all ones.
    mask = (MAX_DW'(1) << dw) - MAX_DW'(1);
    return MAX_DW'(bus >> (idx * dw)) & mask;
  endfunction

endpackage : apb_pkg

// File: rtl/apb_wait_cnt.sv
// -----------------------------------------------------------------------------
// apb_wait_cnt
// Wait-state counter for the APB ACCESS phase. Counts 0..WAIT_STATES and
// saturates there.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   clr     in   force the count to 0 (takes priority over en)
//   en      in   advance the count by one while not done
//   done_o  out  count == WAIT_STATES (completing ACCESS cycle)
//   last_o  out  count == WAIT_STATES-1 (last wait cycle; never set when
//                WAIT_STATES == 0)
// -----------------------------------------------------------------------------
module apb_wait_cnt
  import apb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done_o,
  output logic last_o
);

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] LIMIT_M1 = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == LIMIT);
  assign last_o = (WAIT_STATES != 0) && (cnt_q == LIMIT_M1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !done_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : apb_wait_cnt

// File: rtl/apb_reg_bank.sv
// -----------------------------------------------------------------------------
// apb_reg_bank
// APB slave back-end behind an address decoder. Runs the SETUP/ACCESS protocol
// with WAIT_STATES wait cycles, owns REGWN read/write registers and muxes
// REGRN read-only values supplied from outside.
// Ports:
//   PCLK, PRESET   clock, synchronous active-high reset
//   PSEL, PENABLE  APB select / access-phase enable
//   PWRITE, PWDATA APB direction and write data
//   pselw, pselr   one-hot RW / RO selects from the decoder
//   dec_err        decoder error (bad address, write to RO)
//   ro_data        RO values, element i at [i*DWIDTH +: DWIDTH]
//   PRDATA         read data, non-zero only while PREADY=1
//   PREADY         one-cycle completion pulse (registered)
//   PSLVERR        error response, only while PREADY=1
//   rw_data        RW register contents, same packing as ro_data
//   wr_pulse       one-cycle strobe alongside a newly written value
// -----------------------------------------------------------------------------
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int unsigned       DWIDTH       = 8,
  parameter int unsigned       REGWN        = 5,
  parameter int unsigned       REGRN        = 3,
  parameter int unsigned       WAIT_STATES  = 1,
  parameter logic [DWIDTH-1:0] RW_RESET_VAL = '0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DWIDTH-1:0]       PWDATA,
  input  logic [REGWN-1:0]        pselw,
  input  logic [REGRN-1:0]        pselr,
  input  logic                    dec_err,
  input  logic [REGRN*DWIDTH-1:0] ro_data,
  output logic [DWIDTH-1:0]       PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [REGWN*DWIDTH-1:0] rw_data,
  output logic [REGWN-1:0]        wr_pulse
);

  // Transfer attributes captured when a transfer enters SETUP; the bus and
  // decoder may change afterwards without affecting the transfer.
  typedef struct packed {
    logic              write;
    logic [DWIDTH-1:0] wdata;
    logic [REGWN-1:0]  pselw;
    logic [REGRN-1:0]  pselr;
    logic              dec_err;
  } hold_t;

  apb_state_e state_q, state_d;
  hold_t      hold_q, hold_d, hold_in;

  logic                          pready_q, pready_d;
  logic                          pslverr_q, pslverr_d;
  logic [DWIDTH-1:0]             prdata_q, prdata_d;
  logic [REGWN-1:0]              wr_pulse_q, wr_pulse_d;
  logic [REGWN-1:0][DWIDTH-1:0]  regs_q, regs_d;

  logic              cnt_clr, cnt_en, cnt_done, cnt_last;
  logic              raise, commit, xfer_err, rd_hit;
  logic [DWIDTH-1:0] rd_data, resp_data;
  logic [REGWN-1:0]  wr_sel;

  apb_wait_cnt #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_cnt (
    .clk    (PCLK),
    .rst    (PRESET),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .done_o (cnt_done),
    .last_o (cnt_last)
  );

  assign hold_in = '{write: PWRITE, wdata: PWDATA, pselw: pselw, pselr: pselr, dec_err: dec_err};

  // Decoder error, no target at all, or a write aimed at a read-only slot.
  assign xfer_err = hold_q.dec_err
                  | ((hold_q.pselw == '0) & (hold_q.pselr == '0))
                  | (hold_q.write & (|hold_q.pselr));

  // Isolate the lowest set select bit so a non-one-hot decoder output still
  // writes exactly one register.
  assign wr_sel = hold_q.pselw & (~hold_q.pselw + REGWN'(1));

  // Read mux: lowest set RW select first, then lowest set RO select.
  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    for (int unsigned i = 0; i < REGWN; i++) begin
      if (!rd_hit && hold_q.pselw[i]) begin
        rd_data = regs_q[i];
        rd_hit  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < REGRN; i++) begin
      if (!rd_hit && hold_q.pselr[i]) begin
        rd_data = DWIDTH'(get_slice(MAX_BUS_W'(ro_data), i, DWIDTH));
        rd_hit  = 1'b1;
      end
    end
  end

  // Writes and erroring transfers return zero data.
  assign resp_data = (xfer_err || hold_q.write) ? '0 : rd_data;

  // Protocol FSM. 'raise' marks the edge that starts the PREADY cycle, so the
  // registered response lines up with the completing ACCESS cycle.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    raise   = 1'b0;
    commit  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // PSEL with PENABLE already high is a protocol error and is ignored.
        if (PSEL && !PENABLE) begin
          state_d = ST_SETUP;
          hold_d  = hold_in;
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_clr = 1'b1;
        raise   = (WAIT_STATES == 0);
      end

      ST_ACCESS: begin
        if (!PSEL) begin
          state_d = ST_IDLE;                  // master abort: nothing commits
        end else if (!cnt_done) begin
          cnt_en = 1'b1;
          raise  = cnt_last;
        end else begin
          commit = hold_q.write && !xfer_err;
          if (!PENABLE) begin
            state_d = ST_SETUP;               // back-to-back transfer
            hold_d  = hold_in;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pready_d   = raise;
    pslverr_d  = (raise && xfer_err) ? RESP_ERR : RESP_OK;
    prdata_d   = raise ? resp_data : '0;
    wr_pulse_d = commit ? wr_sel : '0;
    regs_d     = regs_q;
    for (int unsigned i = 0; i < REGWN; i++) begin
      if (commit && wr_sel[i]) begin
        regs_d[i] = hold_q.wdata;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= RESP_OK;
      prdata_q   <= '0;
      wr_pulse_q <= '0;
      // NOTE: the register array is a handful of flops with a defined reset value, so it is reset like any other state.
      regs_q     <= {REGWN{RW_RESET_VAL}};
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  assign PREADY   = pready_q;
  assign PSLVERR  = pslverr_q;
  assign PRDATA   = prdata_q;
  assign wr_pulse = wr_pulse_q;
  assign rw_data  = regs_q;

endmodule : apb_reg_bank

// File: tb/tb_apb_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_apb_reg_bank
// Two instances share the APB bus: u_dut0 (WAIT_STATES=0, reset value 0x5A)
// and u_dut1 (WAIT_STATES=1, reset value 0x00); 'target' steers PSEL to one.
// Expected responses come from a transaction-level model: per-transfer error
// rule, register array per instance, and PREADY at SETUP+1+WAIT_STATES.
// -----------------------------------------------------------------------------
module tb_apb_reg_bank;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        psel_tb, PENABLE, PWRITE, dec_err;
  logic [7:0]  PWDATA;
  logic [4:0]  pselw;
  logic [2:0]  pselr;
  logic [23:0] ro_data;
  int          target;

  logic        psel_i [2];
  logic [7:0]  prdata [2];
  logic        pready [2];
  logic        pslverr[2];
  logic [39:0] rw     [2];
  logic [4:0]  pulse  [2];

  int          ws [2]        = '{0, 1};
  logic [7:0]  rst_val [2]   = '{8'h5A, 8'h00};
  logic [7:0]  mregs [2][5];
  logic [4:0]  exp_pulse [2];
  bit          pend [2];

  int n_checks = 0;
  int n_err    = 0;

  assign psel_i[0] = psel_tb && (target == 0);
  assign psel_i[1] = psel_tb && (target == 1);

  apb_reg_bank #(.DWIDTH(8), .REGWN(5), .REGRN(3), .WAIT_STATES(0), .RW_RESET_VAL(8'h5A)) u_dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_i[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .pselw(pselw), .pselr(pselr), .dec_err(dec_err), .ro_data(ro_data),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]), .rw_data(rw[0]),
    .wr_pulse(pulse[0]));

  apb_reg_bank #(.DWIDTH(8), .REGWN(5), .REGRN(3), .WAIT_STATES(1), .RW_RESET_VAL(8'h00)) u_dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_i[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .pselw(pselw), .pselr(pselr), .dec_err(dec_err), .ro_data(ro_data),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]), .rw_data(rw[1]),
    .wr_pulse(pulse[1]));

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  function automatic int low_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [39:0] mpack(input int d);
    logic [39:0] r;
    for (int i = 0; i < 5; i++) r[i*8 +: 8] = mregs[d][i];
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 5; i++) mregs[d][i] = rst_val[d];
      exp_pulse[d] = '0;
      pend[d]      = 1'b0;
    end
  endtask

  // Cycle after a completed transfer: response gone, write (if any) visible.
  task automatic post_check(input int d);
    check("post_pready",  64'(pready[d]),  64'(0));
    check("post_pslverr", 64'(pslverr[d]), 64'(0));
    check("post_prdata",  64'(prdata[d]),  64'(0));
    check("post_rw_data", 64'(rw[d]),      64'(mpack(d)));
    check("post_pulse",   64'(pulse[d]),   64'(exp_pulse[d]));
    pend[d] = 1'b0;
  endtask

  task automatic check_reset_state(input int d);
    check("rst_pready",  64'(pready[d]),  64'(0));
    check("rst_pslverr", 64'(pslverr[d]), 64'(0));
    check("rst_prdata",  64'(prdata[d]),  64'(0));
    check("rst_pulse",   64'(pulse[d]),   64'(0));
    check("rst_rw_data", 64'(rw[d]),      64'(mpack(d)));
  endtask

  // One APB transfer to instance d. abort drops PSEL in the first wait cycle;
  // chain leaves the bus in SETUP for an immediate next transfer.
  task automatic xfer(input int d, input logic wr, input logic [7:0] wd,
                      input logic [4:0] sw, input logic [2:0] sr, input logic de,
                      input logic [23:0] ro_last, input bit abort, input bit chain);
    logic       err;
    logic [7:0] exp_rd;
    int         w;
    int         idx;
    w       = ws[d];
    target  = d;
    psel_tb = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PWDATA  = wd;
    pselw   = sw;
    pselr   = sr;
    dec_err = de;
    tick();                                   // SETUP cycle
    if (pend[d]) post_check(d);
    else check("setup_pready", 64'(pready[d]), 64'(0));
    // Later bus changes must not affect the captured transfer.
    PENABLE = 1'b1;
    PWRITE  = 1'($urandom);
    PWDATA  = 8'($urandom);
    pselw   = 5'($urandom);
    pselr   = 3'($urandom);
    dec_err = 1'($urandom);
    for (int c = 1; c <= w + 1; c++) begin
      ro_data = (c == w + 1) ? ro_last : 24'($urandom);
      tick();
      if (c == 1) check("pulse_clear", 64'(pulse[d]), 64'(0));
      if (c <= w) begin
        check("wait_pready", 64'(pready[d]), 64'(0));
        if (abort) begin
          psel_tb = 1'b0;
          PENABLE = 1'b0;
          tick();
          check("abort_pready", 64'(pready[d]), 64'(0));
          tick();
          check("abort_pready2", 64'(pready[d]), 64'(0));
          check("abort_rw_data", 64'(rw[d]),     64'(mpack(d)));
          check("abort_pulse",   64'(pulse[d]),  64'(0));
          return;
        end
      end
    end
    err = de || (sw == 5'd0 && sr == 3'd0) || (wr && sr != 3'd0);
    if (err || wr)        exp_rd = 8'h00;
    else if (sw != 5'd0)  exp_rd = mregs[d][low_idx({3'b0, sw})];
    else                  exp_rd = ro_last[low_idx({5'b0, sr})*8 +: 8];
    check("done_pready",  64'(pready[d]),  64'(1));
    check("done_pslverr", 64'(pslverr[d]), 64'(err));
    check("done_prdata",  64'(prdata[d]),  64'(exp_rd));
    exp_pulse[d] = '0;
    if (wr && !err) begin
      idx             = low_idx({3'b0, sw});
      mregs[d][idx]   = wd;
      exp_pulse[d]    = 5'(1) << idx;
    end
    pend[d] = 1'b1;
    if (!chain) begin
      tick();                                 // completing edge with PSEL/PENABLE high
      post_check(d);
      psel_tb = 1'b0;
      PENABLE = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         d, n, kind, idx;
    logic       wr, de;
    logic [4:0] sw;
    logic [2:0] sr;
    bit         ab;

    PRESET = 1'b1; psel_tb = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;
    pselw = '0; pselr = '0; dec_err = 1'b0; ro_data = '0; target = 0;
    model_reset();
    tick(); tick();
    check_reset_state(0);
    check_reset_state(1);
    PRESET = 1'b0;

    // Write 0xA5 to RW reg 2 with one wait state.
    xfer(1, 1'b1, 8'hA5, 5'b00100, 3'b000, 1'b0, 24'($urandom), 1'b0, 1'b0);
    check("wr_a5_slice", 64'(rw[1][23:16]), 64'(8'hA5));
    // Read RO reg 1 = 0x3C, then RW reg 2.
    xfer(1, 1'b0, 8'h00, 5'b00000, 3'b010, 1'b0, 24'h003C00, 1'b0, 1'b0);
    xfer(1, 1'b0, 8'h00, 5'b00100, 3'b000, 1'b0, 24'($urandom), 1'b0, 1'b0);
    // Error transfers: decoder error, write to RO, no select.
    xfer(1, 1'b1, 8'h77, 5'b00000, 3'b001, 1'b1, 24'($urandom), 1'b0, 1'b0);
    xfer(1, 1'b1, 8'h66, 5'b00000, 3'b100, 1'b0, 24'($urandom), 1'b0, 1'b0);
    xfer(1, 1'b0, 8'h00, 5'b00000, 3'b000, 1'b0, 24'($urandom), 1'b0, 1'b0);
    // Abort in first wait cycle.
    xfer(1, 1'b1, 8'h11, 5'b01000, 3'b000, 1'b0, 24'($urandom), 1'b1, 1'b0);
    // Back-to-back writes on both wait-state settings.
    xfer(1, 1'b1, 8'h01, 5'b00001, 3'b000, 1'b0, 24'($urandom), 1'b0, 1'b1);
    xfer(1, 1'b1, 8'h02, 5'b00010, 3'b000, 1'b0, 24'($urandom), 1'b0, 1'b0);
    xfer(0, 1'b1, 8'h01, 5'b00001, 3'b000, 1'b0, 24'($urandom), 1'b0, 1'b1);
    xfer(0, 1'b1, 8'h02, 5'b00010, 3'b000, 1'b0, 24'($urandom), 1'b0, 1'b0);
    xfer(0, 1'b0, 8'h00, 5'b00001, 3'b000, 1'b0, 24'($urandom), 1'b0, 1'b0);

    // PSEL+PENABLE while idle is ignored.
    target = 1; psel_tb = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PWDATA = 8'hFF;
    pselw = 5'b10000; pselr = '0; dec_err = 1'b0;
    tick(); tick();
    check("proto_pready", 64'(pready[1]), 64'(0));
    psel_tb = 1'b0; PENABLE = 1'b0;
    tick();
    check("proto_rw_data", 64'(rw[1]),    64'(mpack(1)));
    check("proto_pulse",   64'(pulse[1]), 64'(0));

    // Randomised transfers, some chained, some aborted.
    for (int it = 0; it < 30; it++) begin
      d = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) begin
        kind = int'($urandom_range(0, 9));
        idx  = int'($urandom_range(0, 4));
        sw = '0; sr = '0; wr = 1'b0;
        if (kind <= 3)      begin wr = 1'b1; sw = 5'(1) << idx; end
        else if (kind <= 5) begin sw = 5'(1) << idx; end
        else if (kind <= 7) begin sr = 3'(1) << (idx % 3); end
        else if (kind == 8) begin wr = 1'b1; sr = 3'(1) << (idx % 3); end
        else                begin wr = 1'($urandom); end
        de = ($urandom_range(0, 7) == 0);
        ab = (ws[d] > 0) && (k == n - 1) && ($urandom_range(0, 5) == 0);
        xfer(d, wr, 8'($urandom), sw, sr, de, 24'($urandom), ab, k < n - 1);
      end
    end

    // Reset held two cycles in the middle of an ACCESS phase.
    xfer(1, 1'b1, 8'h3E, 5'b00001, 3'b000, 1'b0, 24'($urandom), 1'b0, 1'b0);
    target = 1; psel_tb = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PWDATA = 8'hEE;
    pselw = 5'b00001; pselr = '0; dec_err = 1'b0;
    tick();
    PENABLE = 1'b1;
    tick();
    PRESET = 1'b1;
    tick(); tick();
    model_reset();
    check_reset_state(0);
    check_reset_state(1);
    PRESET = 1'b0; psel_tb = 1'b0; PENABLE = 1'b0;
    tick();
    check("rst_after_rw",    64'(rw[1]),     64'(mpack(1)));
    check("rst_after_pulse", 64'(pulse[1]),  64'(0));
    check("rst_after_ready", 64'(pready[1]), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_apb_reg_bank
